la132_sram_slave: RTL and testbench

LA132_SRAM_SLAVE -- requirements
Module: la132_sram_slave

---
 rtl/la132_sram_slave.sv | 167 ++++++++++++++++
 tb/tb_la132_sram_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/la132_sram_slave.sv
// LA132 SRAM slave: byte-enabled word memory with programmable ack wait states and an
// in-order, fixed-latency read-return FIFO. Define LA132_SRAM_SLAVE_STALL_EN for LFSR ack stalls.
module la132_sram_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                MEM_WORDS   = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1c000000,
  parameter int                ACK_LAT     = 0,
  parameter int                RD_LAT      = 1,
  parameter int                OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sram_en,
  input  logic                sram_wr,
  input  logic                sram_fetch,
  input  logic [DATA_W/8-1:0] sram_strb,
  input  logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_wdata,
  output logic                sram_ack,
  output logic                sram_rrdy,
  output logic                sram_resp,
  output logic [DATA_W-1:0]   sram_rdata,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         wr_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int OW = $clog2(OUTSTANDING + 1);
  localparam bit BYPASS = (RD_LAT == 1);
  // The countdown already ticks during the ack cycle, so the stored value is one less.
  localparam logic [3:0] LOAD = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_off;
  logic              in_range;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rd_word;

  assign offset   = sram_addr - BASE_ADDR;
  assign word_off = offset >> SH;
  assign in_range = (sram_addr >= BASE_ADDR) && (word_off < ADDR_W'(MEM_WORDS));
  assign idx      = word_off[IW-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  logic [3:0]        wcnt;
  logic              stall;
  logic              lat_ok;
  logic              full;
  logic              pop;
  logic              ack;
  logic              push;
  logic              direct;
  logic [DATA_W-1:0] f_data [OUTSTANDING];
  logic              f_err  [OUTSTANDING];
  logic [3:0]        f_cnt  [OUTSTANDING];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [OW-1:0]     occ;
  logic              rrdy;
  logic              rerr;
  logic [DATA_W-1:0] rdata;

`ifdef LA132_SRAM_SLAVE_STALL_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, free-running from the reset seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 8'h5A;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign lat_ok = ({1'b0, wcnt} + 5'd1) > 5'(ACK_LAT);
  assign full   = (occ == OW'(OUTSTANDING));
  assign pop    = (occ != '0) && (f_cnt[head] == 4'd0);
  assign ack    = sram_en && !reset && !stall && lat_ok && (sram_wr || !full || pop);
  assign push   = ack && !sram_wr && !BYPASS;
  assign direct = ack && !sram_wr && BYPASS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt      <= 4'd0;
      fetch_cnt <= 16'd0;
      wr_cnt    <= 16'd0;
    end else begin
      if (!sram_en || ack)  wcnt <= 4'd0;
      else if (wcnt != 4'hF) wcnt <= wcnt + 4'd1;
      if (ack && !sram_wr && sram_fetch) fetch_cnt <= sat_inc(fetch_cnt);
      if (ack && sram_wr)                wr_cnt    <= sat_inc(wr_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (ack && sram_wr && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (sram_strb[b]) mem[idx][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop)  head <= bump(head);
      if (push) tail <= bump(tail);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  // Every entry counts down together; the later push assignment wins on its own slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (f_cnt[i] != 4'd0) f_cnt[i] <= f_cnt[i] - 4'd1;
    end
    if (push) begin
      f_data[tail] <= rd_word;
      f_err[tail]  <= !in_range;
      f_cnt[tail]  <= LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrdy  <= 1'b0;
      rerr  <= 1'b0;
      rdata <= '0;
    end else if (pop) begin
      rrdy  <= 1'b1;
      rerr  <= f_err[head];
      rdata <= f_data[head];
    end else if (direct) begin
      rrdy  <= 1'b1;
      rerr  <= !in_range;
      rdata <= rd_word;
    end else begin
      rrdy  <= 1'b0;
      rerr  <= 1'b0;
    end
  end

  assign sram_ack   = ack;
  assign sram_rrdy  = rrdy;
  assign sram_rdata = rdata;
  // Write error (ack cycle) and read error (rrdy cycle) share one flag.
  assign sram_resp  = (ack && sram_wr && !in_range) || rerr;

endmodule

// File: tb/tb_la132_sram_slave.sv
// Bench for la132_sram_slave: three parameterisations driven by random and directed traffic,
// checked cycle by cycle against a transaction-level model of memory and read return times.
module tb_la132_sram_slave;

  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          WORDS = 64;
  localparam int CFG_ACK [3] = '{0, 3, 0};
  localparam int CFG_RD  [3] = '{1, 15, 8};
  localparam int CFG_OUT [3] = '{4, 1, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic        fetch = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  sel = 2'd0;

  logic [2:0]  ack_v, rrdy_v, resp_v;
  logic [31:0] rdata_v [3];
  logic [15:0] fcnt_v [3];
  logic [15:0] wcnt_v [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    la132_sram_slave #(
      .DATA_W(32), .ADDR_W(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE),
      .ACK_LAT(CFG_ACK[g]), .RD_LAT(CFG_RD[g]), .OUTSTANDING(CFG_OUT[g])
    ) dut (
      .clk(clk), .reset(reset),
      .sram_en(en && (sel == 2'(g))), .sram_wr(wr), .sram_fetch(fetch),
      .sram_strb(strb), .sram_addr(addr), .sram_wdata(wdata),
      .sram_ack(ack_v[g]), .sram_rrdy(rrdy_v[g]), .sram_resp(resp_v[g]),
      .sram_rdata(rdata_v[g]), .fetch_cnt(fcnt_v[g]), .wr_cnt(wcnt_v[g])
    );
  end

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rd_t;

  rd_t         q[$];
  logic [31:0] mmem [3][WORDS];
  int          waited, m_fcnt, m_wcnt, cyc, n_chk, n_err;
  int          ack_cyc, rrdy_cyc, rrdy_cnt;
  logic        ack_seen;
  logic        obs_resp, obs_wresp;
  logic [31:0] last_rd, obs_rd;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(WORDS));
  endfunction

  // One bus cycle: predict, compare at the falling edge, then advance the model.
  task automatic step();
    int          pend;
    logic        e_ack, e_rrdy, e_err, e_resp;
    logic [5:0]  w;
    rd_t         r;
    @(negedge clk);
    e_ack  = 1'b0;
    e_rrdy = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      q.delete();
      waited  = 0;
      m_fcnt  = 0;
      m_wcnt  = 0;
      last_rd = 32'h0;
    end else begin
      pend = 0;
      foreach (q[i]) if (q[i].due > cyc + 1) pend++;
      e_ack = en && (waited >= CFG_ACK[sel]) && (wr || pend < CFG_OUT[sel]);
      if (q.size() > 0 && q[0].due == cyc) begin
        e_rrdy  = 1'b1;
        e_err   = q[0].err;
        last_rd = q[0].data;
        void'(q.pop_front());
      end
    end
    e_resp = (e_ack && wr && !in_rng(addr)) || (e_rrdy && e_err);
    check("ack", 64'(ack_v[sel]), 64'(e_ack));
    check("rrdy", 64'(rrdy_v[sel]), 64'(e_rrdy));
    check("resp", 64'(resp_v[sel]), 64'(e_resp));
    check("rdata", 64'(rdata_v[sel]), 64'(last_rd));
    check("fetch_cnt", 64'(fcnt_v[sel]), 64'(16'(m_fcnt)));
    check("wr_cnt", 64'(wcnt_v[sel]), 64'(16'(m_wcnt)));
    if (rrdy_v[sel]) begin
      obs_rd   = rdata_v[sel];
      obs_resp = resp_v[sel];
      rrdy_cyc = cyc;
      rrdy_cnt++;
    end
    ack_seen = e_ack;
    if (e_ack) begin
      ack_cyc = cyc;
      w = 6'((addr - BASE) >> 2);
      if (wr) begin
        obs_wresp = resp_v[sel];
        m_wcnt++;
        if (in_rng(addr))
          for (int b = 0; b < 4; b++) if (strb[b]) mmem[sel][w][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        if (fetch) m_fcnt++;
        r.due  = cyc + CFG_RD[sel];
        r.data = in_rng(addr) ? mmem[sel][w] : 32'h0;
        r.err  = !in_rng(addr);
        q.push_back(r);
      end
    end
    waited = (en && !e_ack && !reset) ? ((waited < 15) ? waited + 1 : 15) : 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input logic w, input logic f, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    int start, n;
    en = 1'b1; wr = w; fetch = f; strb = s; addr = a; wdata = d;
    start = cyc;
    n = 0;
    ack_seen = 1'b0;
    while (!ack_seen && n < 64) begin
      step();
      n++;
    end
    check("ack_bound", 64'(ack_seen), 64'(1));
    lat = ack_cyc - start;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    wr = 1'b0;
    fetch = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    en = 1'b0;
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic init_mem();
    int lat;
    for (int i = 0; i < WORDS; i++) req(1'b1, 1'b0, 4'hF, BASE + 32'(4 * i), $urandom, lat);
    idle(1);
  endtask

  task automatic rand_req();
    logic [31:0] a;
    int          k, lat;
    k = int'($urandom_range(0, 9));
    if (k == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
    else if (k == 1) a = BASE + 32'(4 * (WORDS + $urandom_range(0, 3)));
    else             a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
    req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom), a, $urandom, lat);
    if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
  endtask

  initial begin
    int l0, l1, l2, a1;
    n_chk = 0; n_err = 0; cyc = 0; rrdy_cnt = 0; rrdy_cyc = -100; ack_cyc = -100;
    waited = 0; m_fcnt = 0; m_wcnt = 0; last_rd = 32'h0; obs_rd = 32'h0;
    obs_resp = 1'b0; obs_wresp = 1'b0;

    // Configuration 0: no wait states, one-cycle read latency.
    sel = 2'd0;
    do_reset(3);
    init_mem();
    req(1'b1, 1'b0, 4'hF, 32'h1c000010, 32'hDEADBEEF, l0);
    req(1'b0, 1'b1, 4'h0, 32'h1c000010, 32'h0, l1);
    idle(1);
    check("r027_wr_lat", 64'(l0), 64'(0));
    check("r027_rd_lat", 64'(l1), 64'(0));
    check("r027_rrdy_delay", 64'(rrdy_cyc - ack_cyc), 64'(1));
    check("r027_data", 64'(obs_rd), 64'(32'hDEADBEEF));
    check("r027_resp", 64'(obs_resp), 64'(0));
    req(1'b1, 1'b0, 4'hF, 32'h1c000020, 32'h11223344, l0);
    req(1'b1, 1'b0, 4'b0010, 32'h1c000020, 32'h0000AA00, l0);
    req(1'b0, 1'b0, 4'h0, 32'h1c000020, 32'h0, l0);
    idle(1);
    check("r028_merge", 64'(obs_rd), 64'(32'h1122AA44));
    req(1'b0, 1'b0, 4'h0, 32'h1bfffffc, 32'h0, l0);
    idle(1);
    check("r031_rd_resp", 64'(obs_resp), 64'(1));
    check("r031_rd_data", 64'(obs_rd), 64'(0));
    req(1'b1, 1'b0, 4'hF, BASE + 32'(4 * WORDS), 32'hFFFFFFFF, l0);
    check("r031_wr_resp", 64'(obs_wresp), 64'(1));
    req(1'b0, 1'b0, 4'h0, BASE, 32'h0, l0);
    idle(1);
    check("r031_mem_kept", 64'(obs_rd), 64'(mmem[0][0]));
    repeat (150) rand_req();
    idle(4);

    // Configuration 1: three wait states, single deep FIFO, long latency.
    sel = 2'd1;
    do_reset(2);
    init_mem();
    req(1'b0, 1'b0, 4'h0, BASE + 32'd8, 32'h0, l0);
    check("r029_lat", 64'(l0), 64'(3));
    idle(16);
    repeat (60) rand_req();
    idle(20);

    // Configuration 2: no wait states, two-entry FIFO, eight-cycle latency.
    sel = 2'd2;
    do_reset(2);
    init_mem();
    req(1'b0, 1'b0, 4'h0, BASE, 32'h0, l0);
    a1 = ack_cyc;
    req(1'b0, 1'b0, 4'h0, BASE + 32'd4, 32'h0, l0);
    l1 = ack_cyc;
    req(1'b0, 1'b0, 4'h0, BASE + 32'd8, 32'h0, l0);
    l2 = ack_cyc;
    idle(12);
    check("r030_ack2", 64'(l1 - a1), 64'(1));
    check("r030_ack3", 64'(l2 - a1), 64'(7));
    repeat (100) rand_req();
    idle(12);
    req(1'b1, 1'b0, 4'hF, BASE + 32'd12, 32'hCAFEF00D, l0);
    idle(1);
    req(1'b0, 1'b0, 4'h0, BASE, 32'h0, l0);
    req(1'b0, 1'b0, 4'h0, BASE + 32'd4, 32'h0, l0);
    idle(1);
    do_reset(2);
    rrdy_cnt = 0;
    idle(12);
    check("r032_no_rrdy", 64'(rrdy_cnt), 64'(0));
    req(1'b0, 1'b0, 4'h0, BASE + 32'd12, 32'h0, l0);
    idle(9);
    check("r032_mem_kept", 64'(obs_rd), 64'(32'hCAFEF00D));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
